// File: rtl/response_pkg.sv
// Shared definitions for the response path: framer state encoding and the
// default TYPE constants also used by the request decoder.
package response_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TYPE = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic [7:0] STATUS_CODE   = 8'h00;
  localparam logic [7:0] STATUS_TYPE   = 8'h00;
  localparam logic [7:0] DEF_RESP_BASE = 8'h11;
  localparam logic [7:0] DEF_MAX_CODE  = 8'h08;
  localparam logic [7:0] DEF_ERR_TYPE  = 8'hFF;

endpackage

// File: rtl/response_framer_if.sv
// Request-side and transmitter-side signals of the response framer.
interface response_framer_if #(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_W     = 5
);
  logic                    has_response;
  logic [7:0]              request_code;
  logic [ADDR_W-1:0]       sensor_address;
  logic [8*DATA_BYTES-1:0] data_to_send;
  logic                    tx_ready;
  logic                    response_valid;
  logic [7:0]              response;
  logic                    busy;
  logic                    frame_done;
  logic                    req_dropped;

  modport slave (
    input  has_response, request_code, sensor_address, data_to_send, tx_ready,
    output response_valid, response, busy, frame_done, req_dropped
  );

  modport master (
    output has_response, request_code, sensor_address, data_to_send, tx_ready,
    input  response_valid, response, busy, frame_done, req_dropped
  );
endinterface

// File: rtl/response_code_map.sv
// Maps a request code to the TYPE byte of the response frame; known=0 marks
// an unrecognised code whose payload must be suppressed.
module response_code_map
  import response_pkg::*;
#(
  parameter logic [7:0] RESP_BASE = DEF_RESP_BASE,
  parameter logic [7:0] MAX_CODE  = DEF_MAX_CODE,
  parameter logic [7:0] ERR_TYPE  = DEF_ERR_TYPE
) (
  input  logic [7:0] code,
  output logic [7:0] type_byte,
  output logic       known
);

  always_comb begin
    type_byte = ERR_TYPE;
    known     = 1'b0;
    if (code == STATUS_CODE) begin
      type_byte = STATUS_TYPE;
      known     = 1'b1;
    end else if (code <= MAX_CODE) begin
      type_byte = RESP_BASE + code;
      known     = 1'b1;
    end
  end

endmodule

// File: rtl/response_framer.sv
// Serialises a completed sensor request into [TYPE][ADDR?][DATA MSB-first]
// bytes over a valid/ready handshake towards the UART transmitter.
module response_framer
  import response_pkg::*;
#(
  parameter int         DATA_BYTES = 2,
  parameter int         ADDR_EN    = 1,
  parameter int         ADDR_W     = 5,
  parameter logic [7:0] RESP_BASE  = DEF_RESP_BASE,
  parameter logic [7:0] MAX_CODE   = DEF_MAX_CODE,
  parameter logic [7:0] ERR_TYPE   = DEF_ERR_TYPE
) (
  input  logic             clock,
  input  logic             reset,
  response_framer_if.slave bus
);

  localparam int         PW   = 8 * DATA_BYTES;
  localparam logic [1:0] LAST = 2'(DATA_BYTES - 1);

  state_t            state, state_nx;
  logic [1:0]        cnt, cnt_nx;
  logic [7:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PW-1:0]     payload_q;
  logic              done_q, dropped_q;

  logic [7:0] map_type;
  logic       map_known;
  logic       active, xfer, last_xfer;
  logic [7:0] data_byte, resp_byte;

  response_code_map #(
    .RESP_BASE (RESP_BASE),
    .MAX_CODE  (MAX_CODE),
    .ERR_TYPE  (ERR_TYPE)
  ) u_code_map (
    .code      (bus.request_code),
    .type_byte (map_type),
    .known     (map_known)
  );

  assign active    = (state != ST_IDLE);
  assign xfer      = active && bus.tx_ready;
  assign last_xfer = (state == ST_DATA) && xfer && (cnt == LAST);

  // cnt counts from the MSB byte down to the LSB byte of the payload
  always_comb begin
    data_byte = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (cnt == 2'(DATA_BYTES - 1 - i)) data_byte = payload_q[8*i +: 8];
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    resp_byte = 8'h00;
    case (state)
      ST_IDLE: begin
        if (bus.has_response) state_nx = ST_TYPE;
      end
      ST_TYPE: begin
        resp_byte = type_q;
        if (xfer) begin
          state_nx = (ADDR_EN != 0) ? ST_ADDR : ST_DATA;
          cnt_nx   = 2'd0;
        end
      end
      ST_ADDR: begin
        resp_byte = 8'(addr_q);
        if (xfer) begin
          state_nx = ST_DATA;
          cnt_nx   = 2'd0;
        end
      end
      ST_DATA: begin
        resp_byte = data_byte;
        if (xfer) begin
          if (cnt == LAST) state_nx = ST_IDLE;
          else             cnt_nx   = cnt + 2'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 2'd0;
      type_q    <= 8'h00;
      addr_q    <= '0;
      payload_q <= '0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      done_q    <= last_xfer;
      dropped_q <= active && bus.has_response;
      // Inputs are captured only here; later changes cannot disturb the frame
      if (!active && bus.has_response) begin
        type_q    <= map_type;
        addr_q    <= bus.sensor_address;
        payload_q <= map_known ? bus.data_to_send : '0;
      end
    end
  end

  assign bus.response_valid = active;
  assign bus.busy           = active;
  assign bus.response       = resp_byte;
  assign bus.frame_done     = done_q;
  assign bus.req_dropped    = dropped_q;

endmodule
